flash_stream_player: RTL
========================

// Module: flash_stream_player
// PURPOSE
//  Parametrised flash audio streamer. Plays samples packed in 32-bit flash words over an inclusive
//  byte range [start_addr,end_addr], one sample per sample_tick edge, to the audio DAC path.
//  Prefetches the next flash word while the current one plays, so there is no gap between words.
//  Sits between the sequencer/keyboard control FSM and the flash controller's Avalon-MM read port.
// PARAMETERS
//  SAMPLE_W     8   sample width in bits; legal 8 or 16; SPW = 32/SAMPLE_W samples per word
//  BYTE_ADDR_W  24  byte-address width; flash_addr is BYTE_ADDR_W-2 bits wide (word address)
// PORTS
//  clk50M              in   1            system clock
//  reset               in   1            asynchronous, active-high reset
//  start               in   1            1-cycle request; sampled only in IDLE
//  start_addr          in   BYTE_ADDR_W  first byte of clip, latched on accepted start
//  end_addr            in   BYTE_ADDR_W  last byte of clip (inclusive), latched on accepted start
//  silent              in   1            mute: audio_out forced 0, playback still advances
//  sample_tick         in   1            async rate clock (e.g. 22 kHz); rising edge = one sample
//  flash_read          out  1            Avalon read request
//  flash_addr          out  BYTE_ADDR_W-2  word address
//  flash_waitrequest   in   1            read is accepted on a cycle with flash_read=1 and waitrequest=0
//  flash_readdatavalid in   1            flash_readdata is valid this cycle
//  flash_readdata      in   32           little-endian packed samples; sample k is at [k*SAMPLE_W +: SAMPLE_W]
//  audio_out           out  SAMPLE_W     current sample, held between ticks
//  busy                out  1            high from accepted start until done
//  done                out  1            1-cycle pulse after the last sample has been emitted
//  underrun            out  1            1-cycle pulse when a tick finds no buffered word
// BEHAVIOUR
//  Reset (async): all outputs 0; FSM -> IDLE; buffers invalid; any outstanding read is abandoned.
//  Tick detection: sample_tick passes through a 2-FF synchroniser, then a rising-edge detect.
//  - One internal tick = 1 cycle, 3 cycles after the raw edge.
//  Sample indexing: the first sample is start_addr[1:0]/(SAMPLE_W/8); the last is end_addr[1:0]/(SAMPLE_W/8).
//  - For SAMPLE_W=16, address bit 0 is ignored.
//  FSM states: IDLE, FETCH, WAIT_DATA, PLAY, FINISH.
//   IDLE      : start=1 -> latch addresses, set busy.
//               - end word < start word -> FINISH with no read.
//               - otherwise -> FETCH.
//   FETCH     : flash_read=1, flash_addr=next word; hold both until waitrequest=0 -> WAIT_DATA.
//   WAIT_DATA : on readdatavalid, load cur_word -> PLAY.
//   PLAY      : each tick emits the current sample; index++.
//               - Prefetch: while in PLAY, if nxt_word is invalid and a next word exists, issue one read.
//                 nxt_word becomes valid on readdatavalid.
//               - Word exhausted on a tick: if nxt_word is valid, cur<=nxt and the index wraps to 0
//                 on the same tick, with no lost tick.
//               - Underrun: if nxt_word is invalid, pulse underrun, hold audio_out, emit the missed
//                 sample on the next tick.
//               - Last sample of the last word emitted -> FINISH.
//   FINISH    : done=1 for 1 cycle, busy=0 -> IDLE.
//  At most one read is outstanding. flash_addr increments modulo 2^(BYTE_ADDR_W-2).
//  - Word-address wrap past the top is not an error.
//  Latency: first sample appears on the first tick after the first readdatavalid.
//  - Ticks arriving before that are dropped and do not count as underrun.
//  silent: audio_out=0 on every emitted sample; indexes, reads and done are unchanged.
//  start while busy is ignored. Start and end in the same word plays only that word's sample span.
// CONFIGURATION
//  PLAYER_REVERSE_EN defined:
//  - Adds input port reverse (1 bit), latched on accepted start.
//  - reverse=1: playback begins at end_addr's sample and walks down to start_addr's sample.
//    Word address decrements; the in-word index counts SPW-1 -> 0.
//  PLAYER_REVERSE_EN undefined: no reverse port; forward playback only.
// TESTING
//  1. SAMPLE_W=8, start_addr=0x10, end_addr=0x17, words 0x44332211, 0x88776655, 8 ticks
//     -> audio_out 11,22,...,88; exactly 2 reads; done pulses once.
//  2. start_addr=0x12, end_addr=0x15, same data -> samples 33,44,55,66 only; done after the 4th tick.
//  3. SAMPLE_W=16, start_addr=0x0, end_addr=0x7, words 0xBBBBAAAA, 0xDDDDCCCC
//     -> AAAA,BBBB,CCCC,DDDD; no gap at the word boundary.
//  4. Hold waitrequest=1 for 200 cycles on the 2nd read, ticks every 50 cycles
//     -> underrun pulses, audio_out holds, every sample is still emitted in order.
//  5. Assert reset mid-PLAY (3rd sample) -> flash_read=0, busy=0, audio_out=0 immediately;
//     a new start replays from the beginning.
//  6. start_addr=0x20, end_addr=0x1F -> no flash_read; done 2 cycles after start; silent=1 run -> all zeros.

Source files
------------

// File: rtl/flash_stream_player.sv
// rtl/flash_stream_player.sv - flash-backed audio sample streamer with one-word prefetch
// Purpose: plays SAMPLE_W-bit samples packed little-endian in 32-bit flash words over the
//          inclusive byte range [start_addr,end_addr], one sample per sample_tick rising edge.
// Optional feature macro: PLAYER_REVERSE_EN (adds input reverse; plays end -> start).
// Ports:
//   clk50M, reset             clock, asynchronous active-high reset
//   start, start_addr,
//   end_addr, silent          clip request (sampled in IDLE only), mute
//   sample_tick               asynchronous sample-rate clock
//   flash_read, flash_addr,
//   flash_waitrequest,
//   flash_readdatavalid,
//   flash_readdata            Avalon-MM read master (word addressed)
//   audio_out, busy, done,
//   underrun                  sample output and status
module flash_stream_player #(
    parameter int SAMPLE_W    = 8,
    parameter int BYTE_ADDR_W = 24
) (
    input  logic                   clk50M,
    input  logic                   reset,
    input  logic                   start,
`ifdef PLAYER_REVERSE_EN
    input  logic                   reverse,
`endif
    input  logic [BYTE_ADDR_W-1:0] start_addr,
    input  logic [BYTE_ADDR_W-1:0] end_addr,
    input  logic                   silent,
    input  logic                   sample_tick,
    output logic                   flash_read,
    output logic [BYTE_ADDR_W-3:0] flash_addr,
    input  logic                   flash_waitrequest,
    input  logic                   flash_readdatavalid,
    input  logic [31:0]            flash_readdata,
    output logic [SAMPLE_W-1:0]    audio_out,
    output logic                   busy,
    output logic                   done,
    output logic                   underrun
);

    localparam int SPW    = 32 / SAMPLE_W;
    localparam int IDX_W  = $clog2(SPW);
    localparam int WORD_W = BYTE_ADDR_W - 2;
    localparam int CNT_W  = WORD_W + 1;
    localparam int IDX_SH = (SAMPLE_W == 16) ? 1 : 0;
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(SPW - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT_DATA,
        S_PLAY,
        S_FINISH
    } state_t;

    state_t                state_q, state_d;
    logic                  tick_s1_q, tick_s1_d;
    logic                  tick_s2_q, tick_s2_d;
    logic                  tick_s3_q, tick_s3_d;
    logic                  tick_q, tick_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  underrun_q, underrun_d;
    logic [SAMPLE_W-1:0]   audio_q, audio_d;
    logic                  rev_q, rev_d;
    logic [IDX_W-1:0]      first_idx_q, first_idx_d;
    logic [IDX_W-1:0]      stop_idx_q, stop_idx_d;
    logic [WORD_W-1:0]     fetch_addr_q, fetch_addr_d;
    logic [CNT_W-1:0]      rem_q, rem_d;          // words not yet requested
    logic                  rd_pf_q, rd_pf_d;      // prefetch read request held until accepted
    logic                  pend_q, pend_d;        // one read accepted, data not yet returned
    logic                  pend_last_q, pend_last_d;
    logic [31:0]           cur_word_q, cur_word_d;
    logic [IDX_W-1:0]      cur_idx_q, cur_idx_d;
    logic                  cur_last_q, cur_last_d;
    logic                  cur_valid_q, cur_valid_d;
    logic [31:0]           nxt_word_q, nxt_word_d;
    logic                  nxt_last_q, nxt_last_d;
    logic                  nxt_valid_q, nxt_valid_d;

    logic                  rev_in;
    logic [WORD_W-1:0]     s_word, e_word;
    logic [1:0]            s_lo, e_lo;
    logic [IDX_W-1:0]      s_idx, e_idx;
    logic                  clip_empty;
    logic [CNT_W-1:0]      clip_words;
    logic                  rd_accept, rd_data;
    logic [IDX_W-1:0]      word_start, word_end;
    logic                  src_valid, src_from_nxt, src_last;
    logic [31:0]           src_word;
    logic [IDX_W-1:0]      src_idx, src_stop, idx_step;
    logic [SAMPLE_W-1:0]   src_sample;

`ifdef PLAYER_REVERSE_EN
    assign rev_in = reverse;
`else
    assign rev_in = 1'b0;
`endif

    assign s_word     = start_addr[BYTE_ADDR_W-1:2];
    assign e_word     = end_addr[BYTE_ADDR_W-1:2];
    assign s_lo       = start_addr[1:0] >> IDX_SH;
    assign e_lo       = end_addr[1:0] >> IDX_SH;
    assign s_idx      = s_lo[IDX_W-1:0];
    assign e_idx      = e_lo[IDX_W-1:0];
    // Compare at sample granularity so a reversed span inside one word is also empty.
    assign clip_empty = {e_word, e_idx} < {s_word, s_idx};
    assign clip_words = {1'b0, e_word} - {1'b0, s_word} + CNT_W'(1);

    assign flash_read = (state_q == S_FETCH) | rd_pf_q;
    assign flash_addr = fetch_addr_q;
    assign rd_accept  = flash_read & ~flash_waitrequest;
    assign rd_data    = flash_readdatavalid & pend_q;

    assign word_start = rev_q ? IDX_MAX : '0;
    assign word_end   = rev_q ? '0 : IDX_MAX;

    // When the current word is exhausted, a tick may take its sample straight from the
    // prefetched word so a word arriving just in time is never reported as an underrun.
    assign src_from_nxt = ~cur_valid_q;
    assign src_valid    = cur_valid_q | nxt_valid_q;
    assign src_word     = cur_valid_q ? cur_word_q : nxt_word_q;
    assign src_idx      = cur_valid_q ? cur_idx_q : word_start;
    assign src_last     = cur_valid_q ? cur_last_q : nxt_last_q;
    assign src_stop     = src_last ? stop_idx_q : word_end;
    assign idx_step     = rev_q ? src_idx - IDX_W'(1) : src_idx + IDX_W'(1);
    assign src_sample   = src_word[int'(src_idx) * SAMPLE_W +: SAMPLE_W];

    assign audio_out = audio_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign underrun  = underrun_q;

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        underrun_d  = 1'b0;
        audio_d     = audio_q;
        rev_d       = rev_q;
        first_idx_d = first_idx_q;
        stop_idx_d  = stop_idx_q;
        fetch_addr_d = fetch_addr_q;
        rem_d       = rem_q;
        rd_pf_d     = rd_pf_q;
        pend_d      = pend_q;
        pend_last_d = pend_last_q;
        cur_word_d  = cur_word_q;
        cur_idx_d   = cur_idx_q;
        cur_last_d  = cur_last_q;
        cur_valid_d = cur_valid_q;
        nxt_word_d  = nxt_word_q;
        nxt_last_d  = nxt_last_q;
        nxt_valid_d = nxt_valid_q;
        tick_s1_d   = sample_tick;
        tick_s2_d   = tick_s1_q;
        tick_s3_d   = tick_s2_q;
        tick_d      = tick_s2_q & ~tick_s3_q;

        if (rd_data) begin
            pend_d = 1'b0;
        end
        if (rd_accept) begin
            fetch_addr_d = rev_q ? fetch_addr_q - WORD_W'(1) : fetch_addr_q + WORD_W'(1);
            rem_d        = rem_q - CNT_W'(1);
            pend_d       = 1'b1;
            pend_last_d  = (rem_q == CNT_W'(1));
            rd_pf_d      = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    busy_d       = 1'b1;
                    rev_d        = rev_in;
                    first_idx_d  = rev_in ? e_idx : s_idx;
                    stop_idx_d   = rev_in ? s_idx : e_idx;
                    fetch_addr_d = rev_in ? e_word : s_word;
                    rem_d        = clip_words;
                    rd_pf_d      = 1'b0;
                    pend_d       = 1'b0;
                    cur_valid_d  = 1'b0;
                    nxt_valid_d  = 1'b0;
                    state_d      = clip_empty ? S_FINISH : S_FETCH;
                end
            end
            S_FETCH: begin
                if (rd_accept) begin
                    state_d = S_WAIT_DATA;
                end
            end
            S_WAIT_DATA: begin
                if (rd_data) begin
                    cur_word_d  = flash_readdata;
                    cur_idx_d   = first_idx_q;
                    cur_last_d  = pend_last_q;
                    cur_valid_d = 1'b1;
                    state_d     = S_PLAY;
                end
            end
            S_PLAY: begin
                if (!rd_pf_q && !pend_q && !nxt_valid_q && rem_q != '0) begin
                    rd_pf_d = 1'b1;
                end
                if (tick_q) begin
                    if (!src_valid) begin
                        underrun_d = 1'b1;
                    end else begin
                        audio_d = silent ? '0 : src_sample;
                        if (src_idx == src_stop) begin
                            if (src_last) begin
                                cur_valid_d = 1'b0;
                                nxt_valid_d = 1'b0;
                                state_d     = S_FINISH;
                            end else if (!src_from_nxt && nxt_valid_q) begin
                                cur_word_d  = nxt_word_q;
                                cur_idx_d   = word_start;
                                cur_last_d  = nxt_last_q;
                                nxt_valid_d = 1'b0;
                            end else begin
                                cur_valid_d = 1'b0;
                                if (src_from_nxt) begin
                                    nxt_valid_d = 1'b0;
                                end
                            end
                        end else begin
                            cur_word_d  = src_word;
                            cur_idx_d   = idx_step;
                            cur_last_d  = src_last;
                            cur_valid_d = 1'b1;
                            if (src_from_nxt) begin
                                nxt_valid_d = 1'b0;
                            end
                        end
                    end
                end else if (!cur_valid_q && nxt_valid_q) begin
                    cur_word_d  = nxt_word_q;
                    cur_idx_d   = word_start;
                    cur_last_d  = nxt_last_q;
                    cur_valid_d = 1'b1;
                    nxt_valid_d = 1'b0;
                end
                if (rd_data) begin
                    nxt_word_d  = flash_readdata;
                    nxt_last_d  = pend_last_q;
                    nxt_valid_d = 1'b1;
                end
            end
            S_FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                rd_pf_d = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk50M or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            tick_s1_q    <= 1'b0;
            tick_s2_q    <= 1'b0;
            tick_s3_q    <= 1'b0;
            tick_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            underrun_q   <= 1'b0;
            audio_q      <= '0;
            rev_q        <= 1'b0;
            first_idx_q  <= '0;
            stop_idx_q   <= '0;
            fetch_addr_q <= '0;
            rem_q        <= '0;
            rd_pf_q      <= 1'b0;
            pend_q       <= 1'b0;
            pend_last_q  <= 1'b0;
            cur_word_q   <= '0;
            cur_idx_q    <= '0;
            cur_last_q   <= 1'b0;
            cur_valid_q  <= 1'b0;
            nxt_word_q   <= '0;
            nxt_last_q   <= 1'b0;
            nxt_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_s1_q    <= tick_s1_d;
            tick_s2_q    <= tick_s2_d;
            tick_s3_q    <= tick_s3_d;
            tick_q       <= tick_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            underrun_q   <= underrun_d;
            audio_q      <= audio_d;
            rev_q        <= rev_d;
            first_idx_q  <= first_idx_d;
            stop_idx_q   <= stop_idx_d;
            fetch_addr_q <= fetch_addr_d;
            rem_q        <= rem_d;
            rd_pf_q      <= rd_pf_d;
            pend_q       <= pend_d;
            pend_last_q  <= pend_last_d;
            cur_word_q   <= cur_word_d;
            cur_idx_q    <= cur_idx_d;
            cur_last_q   <= cur_last_d;
            cur_valid_q  <= cur_valid_d;
            nxt_word_q   <= nxt_word_d;
            nxt_last_q   <= nxt_last_d;
            nxt_valid_q  <= nxt_valid_d;
        end
    end

endmodule
